// File: rtl/bcd_addsub_serial.sv
//============================================================================
// Module   : bcd_addsub_serial
// Brief    : Digit-serial packed-BCD adder/subtractor, LSD first, one decimal
//            digit per clock behind valid/ready handshakes.
// Revision : 1.0
//============================================================================
`default_nettype none

module bcd_addsub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [4*DIGITS-1:0]   a_i,
    input  logic [4*DIGITS-1:0]   b_i,
    input  logic                  cin_i,
    input  logic                  sub_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [4*DIGITS-1:0]   sum_o,
    output logic                  cout_o,
    output logic                  err_o
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [4*DIGITS-1:0] a_q;
    logic [4*DIGITS-1:0] b_q;
    logic                sub_q;
    logic                carry_q;
    logic [IDXW-1:0]     idx_q;
    logic [4*DIGITS-1:0] sum_q;
    logic                cout_q;
    logic                err_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [3:0]          a_dig_d;
    logic [3:0]          b_dig_d;
    logic [3:0]          bd_d;
    logic [4:0]          t_d;
    logic [3:0]          digit_d;
    logic                carry_d;
    logic                err_d;

    // Any digit of either incoming operand outside 0..9 poisons the result.
    always_comb begin
        err_d = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (a_i[4*k +: 4] > 4'd9 || b_i[4*k +: 4] > 4'd9) begin
                err_d = 1'b1;
            end
        end
    end

    // Single decimal-correct digit adder shared across all digit positions.
    always_comb begin
        a_dig_d = a_q[4*idx_q +: 4];
        b_dig_d = b_q[4*idx_q +: 4];
        bd_d    = sub_q ? (4'd9 - b_dig_d) : b_dig_d;
        t_d     = {1'b0, a_dig_d} + {1'b0, bd_d} + {4'b0000, carry_q};
        if (t_d > 5'd9) begin
            digit_d = t_d[3:0] + 4'd6;
            carry_d = 1'b1;
        end else begin
            digit_d = t_d[3:0];
            carry_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        a_q        <= a_i;
                        b_q        <= b_i;
                        sub_q      <= sub_i;
                        carry_q    <= cin_i;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        err_q      <= err_d;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[4*idx_q +: 4] <= digit_d;
                    carry_q             <= carry_d;
                    idx_q               <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                        // Later assignment wins over the digit write above.
                        if (err_q) begin
                            sum_q  <= '0;
                            cout_q <= 1'b0;
                        end else begin
                            cout_q <= carry_d;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_addsub_serial.sv
//============================================================================
// Module   : tb_bcd_addsub_serial
// Brief    : Directed plus randomized bench for bcd_addsub_serial (DIGITS=4)
//            against a decimal-arithmetic reference model.
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_bcd_addsub_serial;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   a = '0;
    logic [15:0]   b = '0;
    logic          cin = 1'b0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   sum;
    logic          cout;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_addsub_serial #(.DIGITS(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .sub_i       (sub),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .err_o       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit has_bad(input logic [15:0] v);
        for (int k = 0; k < D; k++) if (v[4*k +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r = '0;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    // Decimal reference: nine's complement of B is (10^D - 1) - B.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mcin,
                         input logic msub, output logic [15:0] es, output logic ec,
                         output logic ee);
        int av, bv, r;
        if (has_bad(ma) || has_bad(mb)) begin
            es = '0; ec = 1'b0; ee = 1'b1;
        end else begin
            av = bcd2int(ma);
            bv = bcd2int(mb);
            if (msub) bv = 9999 - bv;
            r  = av + bv + int'(mcin);
            ec = (r >= 10000);
            es = int2bcd(r % 10000);
            ee = 1'b0;
        end
    endtask

    function automatic logic [15:0] rand_bcd(input bit allow_bad);
        logic [15:0] r;
        for (int k = 0; k < D; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && ($urandom_range(0, 7) == 0))
            r[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    // Starts at a point just after an edge (or at a negedge) with the DUT idle.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tcin, input logic tsub, input bit handshake);
        logic [15:0] es;
        logic        ec, ee;
        int          lat;
        model(ta, tb, tcin, tsub, es, ec, ee);
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(D));
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_err"}, 32'(err), 32'(ee));
        if (handshake) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
            chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [15:0] hs;
        logic        hc, he;

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout_err", {30'd0, cout, err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Early out_ready while idle must not disturb anything.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_out_ready_noeffect", 32'(out_valid), 32'd0);

        run_op("add_basic",  16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
        chk("add_basic_value", 32'(sum), 32'h0002);
        run_op("carry_chain", 16'h9999, 16'h9999, 1'b1, 1'b0, 1'b1);
        chk("carry_chain_value", {15'd0, cout, sum}, {15'd0, 1'b1, 16'h9999});
        run_op("sub_pos",    16'h0041, 16'h0011, 1'b1, 1'b1, 1'b1);
        chk("sub_pos_value", {15'd0, cout, sum}, {15'd0, 1'b1, 16'h0030});
        run_op("sub_neg",    16'h0011, 16'h0041, 1'b1, 1'b1, 1'b1);
        chk("sub_neg_value", {15'd0, cout, sum}, {15'd0, 1'b0, 16'h9970});
        run_op("bad_digit",  16'h00A1, 16'h0001, 1'b0, 1'b0, 1'b1);
        run_op("after_bad",  16'h0010, 16'h0005, 1'b0, 1'b0, 1'b1);
        chk("after_bad_value", {15'd0, err, sum}, {15'd0, 1'b0, 16'h0015});

        // Backpressure with competing operands on the input side.
        run_op("bp", 16'h2468, 16'h1357, 1'b0, 1'b0, 1'b0);
        model(16'h2468, 16'h1357, 1'b0, 1'b0, hs, hc, he);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1; sub = 1'b1;
            @(posedge clk); #1;
            chk("bp_sum_hold", 32'(sum), 32'(hs));
            chk("bp_flags_hold", {29'd0, out_valid, cout, err}, {29'd0, 1'b1, hc, he});
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_not_captured", 32'(sum), 32'(hs));

        // Reset in the middle of RUN.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout_err", {30'd0, cout, err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op("post_rst", 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1);
        chk("post_rst_value", {15'd0, cout, sum}, {15'd0, 1'b0, 16'h0010});

        for (int i = 0; i < 40; i++) begin
            run_op("rand", rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom), 1'($urandom), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
